// File: rtl/l2_bank_timing_model.sv
// Timing model of one L2 cache bank: direct-mapped tag/valid/dirty store, per-thread stall
// counters, and registered hit/miss/writeback event pulses, one decision per thread token.
module l2_bank_timing_model #(
  parameter int unsigned NTHREADS      = 64,
  parameter int unsigned OFFSET_BITS   = 5,
  parameter int unsigned MAX_SETS_LOG2 = 10,
  parameter int unsigned LAT_W         = 10
) (
  input  logic                        gclk,
  input  logic                        rst,
  input  logic                        run_reg,
  input  logic [3:0]                  log2_num_sets,
  input  logic [LAT_W-1:0]            hit_latency,
  input  logic [LAT_W-1:0]            dram_latency,
  input  logic                        token_valid,
  input  logic [$clog2(NTHREADS)-1:0] tid,
  input  logic                        request_valid,
  input  logic [31:0]                 request_addr,
  input  logic                        writeback_valid,
  input  logic [31:0]                 writeback_addr,
  output logic                        stay_stalled,
  output logic                        ctr_hit,
  output logic                        ctr_miss,
  output logic [1:0]                  ctr_writeback
);

  localparam int unsigned NumSets = 1 << MAX_SETS_LOG2;
  localparam int unsigned TagW    = 32 - OFFSET_BITS;

  typedef logic [MAX_SETS_LOG2-1:0] idx_t;
  typedef logic [TagW-1:0]          tag_t;

  logic [NumSets-1:0] valid_q, valid_d;
  logic [NumSets-1:0] dirty_q, dirty_d;
  tag_t               tag_q [NumSets];
  logic [LAT_W-1:0]   stall_q [NTHREADS];
  logic               ctr_hit_q, ctr_miss_q;
  logic [1:0]         ctr_wb_q;

  function automatic idx_t set_index(input logic [31:0] addr, input logic [3:0] sets_log2);
    idx_t idx;
    idx = addr[OFFSET_BITS +: MAX_SETS_LOG2];
    for (int i = 0; i < int'(MAX_SETS_LOG2); i++) begin
      if (i >= int'(sets_log2)) idx[i] = 1'b0;
    end
    return idx;
  endfunction

  logic             active, stalled;
  logic [LAT_W-1:0] cur_cnt, cnt_d, miss_lat;
  logic [LAT_W:0]   lat_sum;
  idx_t             wb_idx, rq_idx;
  tag_t             wb_tag, rq_tag, rq_line_tag;
  logic             wb_do, wb_hit, wb_alloc, wb_evict;
  logic             same_set, rq_line_valid, rq_line_dirty;
  logic             rq_do, rq_hit, rq_miss, rq_evict;
  logic             unused_offset;

  assign unused_offset = ^{request_addr[OFFSET_BITS-1:0], writeback_addr[OFFSET_BITS-1:0]};

  assign active  = run_reg & token_valid;
  assign cur_cnt = stall_q[tid];
  assign stalled = (cur_cnt != '0);

  assign wb_idx = set_index(writeback_addr, log2_num_sets);
  assign rq_idx = set_index(request_addr, log2_num_sets);
  assign wb_tag = writeback_addr[31:OFFSET_BITS];
  assign rq_tag = request_addr[31:OFFSET_BITS];

  assign wb_do    = active & writeback_valid;
  assign wb_hit   = valid_q[wb_idx] & (tag_q[wb_idx] == wb_tag);
  assign wb_alloc = wb_do & ~wb_hit;
  assign wb_evict = wb_alloc & valid_q[wb_idx] & dirty_q[wb_idx];

  // The request observes the store as already updated by a same-token writeback.
  assign same_set      = wb_do & (wb_idx == rq_idx);
  assign rq_line_valid = same_set | valid_q[rq_idx];
  assign rq_line_dirty = same_set | dirty_q[rq_idx];
  assign rq_line_tag   = same_set ? wb_tag : tag_q[rq_idx];

  assign rq_do    = active & ~stalled & request_valid;
  assign rq_hit   = rq_line_valid & (rq_line_tag == rq_tag);
  assign rq_miss  = rq_do & ~rq_hit;
  assign rq_evict = rq_miss & rq_line_valid & rq_line_dirty;

  assign lat_sum  = {1'b0, hit_latency} + {1'b0, dram_latency};
  assign miss_lat = lat_sum[LAT_W] ? '1 : lat_sum[LAT_W-1:0];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wb_do) begin
      valid_d[wb_idx] = 1'b1;
      dirty_d[wb_idx] = 1'b1;
    end
    if (rq_miss) begin
      valid_d[rq_idx] = 1'b1;
      dirty_d[rq_idx] = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cur_cnt;
    if (stalled) begin
      cnt_d = cur_cnt - 1'b1;
    end else if (rq_do) begin
      cnt_d = rq_hit ? hit_latency : miss_lat;
    end
  end

  always_ff @(posedge gclk) begin
    if (!rst) begin
      valid_q    <= '0;
      dirty_q    <= '0;
      ctr_hit_q  <= 1'b0;
      ctr_miss_q <= 1'b0;
      ctr_wb_q   <= '0;
      for (int i = 0; i < int'(NTHREADS); i++) stall_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      ctr_hit_q  <= rq_do & rq_hit;
      ctr_miss_q <= rq_miss;
      ctr_wb_q   <= 2'(wb_evict) + 2'(rq_evict);
      if (active) stall_q[tid] <= cnt_d;
    end
  end

  // Tags are qualified by valid bits, so they need no reset.
  always_ff @(posedge gclk) begin
    if (wb_alloc) tag_q[wb_idx] <= wb_tag;
    if (rq_miss)  tag_q[rq_idx] <= rq_tag;
  end

  assign stay_stalled  = active & stalled;
  assign ctr_hit       = ctr_hit_q;
  assign ctr_miss      = ctr_miss_q;
  assign ctr_writeback = ctr_wb_q;

endmodule

// File: tb/tb_l2_bank_timing_model.sv
// Directed bench for l2_bank_timing_model: the driver queues expected per-token responses, a
// negedge monitor pops them and checks stay_stalled and the following cycle's counter pulses.
module tb_l2_bank_timing_model;

  logic        gclk = 1'b0;
  logic        rst = 1'b0;
  logic        run_reg = 1'b1;
  logic [3:0]  log2_num_sets = 4'd2;
  logic [9:0]  hit_latency = 10'd3;
  logic [9:0]  dram_latency = 10'd10;
  logic        token_valid = 1'b0;
  logic [5:0]  tid = '0;
  logic        request_valid = 1'b0;
  logic [31:0] request_addr = '0;
  logic        writeback_valid = 1'b0;
  logic [31:0] writeback_addr = '0;
  logic        stay_stalled, ctr_hit, ctr_miss;
  logic [1:0]  ctr_writeback;

  typedef struct {
    bit       stall;
    bit       hit;
    bit       miss;
    bit [1:0] wb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always #5 gclk = ~gclk;

  l2_bank_timing_model dut (
    .gclk            (gclk),
    .rst             (rst),
    .run_reg         (run_reg),
    .log2_num_sets   (log2_num_sets),
    .hit_latency     (hit_latency),
    .dram_latency    (dram_latency),
    .token_valid     (token_valid),
    .tid             (tid),
    .request_valid   (request_valid),
    .request_addr    (request_addr),
    .writeback_valid (writeback_valid),
    .writeback_addr  (writeback_addr),
    .stay_stalled    (stay_stalled),
    .ctr_hit         (ctr_hit),
    .ctr_miss        (ctr_miss),
    .ctr_writeback   (ctr_writeback)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Entered at posedge+1; presents one token for a full cycle.
  task automatic tok(input int t, input bit rq, input logic [31:0] ra, input bit wb,
                     input logic [31:0] wa, input bit es, input bit eh, input bit em,
                     input bit [1:0] ew);
    exp_t e;
    token_valid     = 1'b1;
    tid             = 6'(t);
    request_valid   = rq;
    request_addr    = ra;
    writeback_valid = wb;
    writeback_addr  = wa;
    e.stall = es; e.hit = eh; e.miss = em; e.wb = ew;
    if (run_reg) exp_q.push_back(e);
    @(posedge gclk);
    #1;
    token_valid     = 1'b0;
    request_valid   = 1'b0;
    writeback_valid = 1'b0;
  endtask

  task automatic idle_toks(input int t, input int n, input bit es);
    for (int i = 0; i < n; i++) tok(t, 1'b0, 32'h0, 1'b0, 32'h0, es, 1'b0, 1'b0, 2'd0);
  endtask

  // Monitor: counters at this negedge belong to the token seen at the previous negedge.
  initial begin
    exp_t     e;
    bit       ph = 1'b0, pm = 1'b0;
    bit [1:0] pw = 2'd0;
    wait (mon_en);
    forever begin
      @(negedge gclk);
      chk("ctr_hit", int'(ctr_hit), int'(ph));
      chk("ctr_miss", int'(ctr_miss), int'(pm));
      chk("ctr_writeback", int'(ctr_writeback), int'(pw));
      ph = 1'b0; pm = 1'b0; pw = 2'd0;
      if (rst && run_reg && token_valid) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("stay_stalled", int'(stay_stalled), int'(e.stall));
          ph = e.hit; pm = e.miss; pw = e.wb;
        end
      end else begin
        chk("stay_stalled_idle", int'(stay_stalled), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge gclk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;

    // Reset state: free thread, no pulses
    idle_toks(0, 1, 1'b0);
    // Cold miss: 13 stalled tokens, then free; same line then hits with 3-token stall
    tok(0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0);
    idle_toks(0, 13, 1'b1);
    tok(0, 1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    idle_toks(0, 3, 1'b1);
    // Dirty eviction
    tok(0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 2'd0);
    tok(1, 1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd1);
    // Combined writeback+request to the same line, clean victim
    tok(0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 2'd0);
    // Stalled request is ignored; stalled writeback still allocates dirty in set 1
    tok(0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2'd0);
    tok(1, 1'b0, 32'h0, 1'b1, 32'h020, 1'b1, 1'b0, 1'b0, 2'd0);
    idle_toks(0, 2, 1'b1);
    tok(6, 1'b1, 32'h420, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd1);
    // Double eviction: writeback evicts dirty line, request then evicts the writeback line
    tok(7, 1'b0, 32'h0, 1'b1, 32'h420, 1'b0, 1'b0, 1'b0, 2'd0);
    tok(7, 1'b1, 32'h0A0, 1'b1, 32'h020, 1'b0, 1'b0, 1'b1, 2'd2);
    // Interleaving threads 2 and 3
    tok(2, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd1);
    tok(3, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      idle_toks(2, 1, 1'b1);
      idle_toks(3, 1, 1'b1);
    end
    idle_toks(3, 1, 1'b0);
    idle_toks(2, 10, 1'b1);
    idle_toks(2, 1, 1'b0);
    // Zero latency: thread proceeds on its next token
    hit_latency  = 10'd0;
    dram_latency = 10'd0;
    tok(4, 1'b1, 32'h000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0);
    tok(4, 1'b1, 32'h000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0);
    idle_toks(4, 1, 1'b0);
    // Saturating miss latency: 1000+100 clamps to 1023
    hit_latency  = 10'd1000;
    dram_latency = 10'd100;
    tok(5, 1'b1, 32'h040, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0);
    idle_toks(5, 1023, 1'b1);
    idle_toks(5, 1, 1'b0);
    // Reset mid-stall
    hit_latency  = 10'd3;
    dram_latency = 10'd10;
    tok(0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0);
    idle_toks(0, 2, 1'b1);
    rst = 1'b0;
    @(posedge gclk);
    #1;
    rst = 1'b1;
    idle_toks(0, 1, 1'b0);
    idle_toks(1, 1, 1'b0);
    // run_reg low: token ignored, so the next read still misses
    run_reg = 1'b0;
    tok(0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    run_reg = 1'b1;
    tok(0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd0);

    repeat (3) @(posedge gclk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_bank_timing_model.md
Name: l2_bank_timing_model

Overview:
- Timing model of one L2 cache bank in the manycore CPU timing-model memory system; the bank-distribution wrapper instantiates one per bank.
- Keeps a direct-mapped tag/valid/dirty store and a per-thread stall counter.
- For each token (one target cycle of one hardware thread), it decides hit, miss or writeback, holds the issuing thread stalled for the modelled latency, and pulses event counters.

Parameters:
- NTHREADS, 64: hardware threads tracked; tid width = log2(NTHREADS).
- OFFSET_BITS, 5: line-offset bits of an address (32-byte lines).
- MAX_SETS_LOG2, 10: log2 of maximum set count; sizes the tag store.
- LAT_W, 10: width of latency fields and stall counters.

Ports:
- gclk.clk, input, 1: single clock; all state updates on rising edge.
- rst, input, 1: reset, synchronous, active-low.
- run_reg, input, 1: model enabled; tokens are ignored when 0.
- log2_num_sets, input, 4: configured sets = 2^log2_num_sets, up to MAX_SETS_LOG2; static while run_reg=1.
- hit_latency, input, LAT_W: L2 hit latency in target cycles.
- dram_latency, input, LAT_W: extra miss latency in target cycles.
- token_valid, input, 1: a target cycle for thread tid is presented this clock.
- tid, input, log2(NTHREADS): thread owning the token.
- request_valid, input, 1: demand access for this bank (qualified by token_valid).
- request_addr, input, 32: byte address of the demand access (bank bits already removed).
- writeback_valid, input, 1: dirty L1 line written to this bank.
- writeback_addr, input, 32: byte address of the writeback.
- stay_stalled, output, 1: thread tid must remain stalled this token.
- ctr_hit, output, 1: hit event pulse.
- ctr_miss, output, 1: miss event pulse.
- ctr_writeback, output, 2: number of dirty evictions to DRAM this event (0..2).

Behaviour:
- Active token = run_reg & token_valid. Nothing changes on any other clock except reset.
- Index = addr[OFFSET_BITS+log2_num_sets-1:OFFSET_BITS]; index bits above log2_num_sets are forced to 0.
- Tag = full line address addr[31:OFFSET_BITS], so tags stay correct for any set count.
- stay_stalled is combinational: run_reg & token_valid & (stall_cnt[tid] != 0).
- Stalled active token:
  - stall_cnt[tid] decrements by 1.
  - request_valid is ignored.
  - writeback_valid is still processed.
- Non-stalled active token with request_valid:
  - Hit (valid and tag match): stall_cnt[tid] <= hit_latency; the hit pulse is raised.
  - Miss: the line is filled (valid=1, dirty=0, new tag); stall_cnt[tid] <= hit_latency + dram_latency, saturating at 2^LAT_W-1; the miss pulse is raised.
  - Miss that evicts a valid dirty victim adds 1 to the writeback count.
- Writeback (active token with writeback_valid, stalled or not):
  - Line present: dirty is set.
  - Line absent: the line is allocated dirty (no stall); if the victim was valid and dirty, 1 is added to the writeback count.
- Request and writeback in the same token: the writeback is applied first, then the request looks up the updated store. A same-line request therefore hits.
- Latency of 0 leaves stall_cnt[tid] = 0, so the thread proceeds on its next token.
- Counter outputs are registered: they reflect the active token of the previous clock and are 0 otherwise. ctr_hit and ctr_miss are mutually exclusive.
- Stall counters of other threads never change on a token for tid.
- Reset (rst=0 at a clock edge):
  - All valid bits, dirty bits and stall counters are cleared.
  - All outputs go to 0 on the next clock.
  - Tag contents are don't-care.
  - An in-flight stall is discarded, even when reset lands mid-stall.
- Changing log2_num_sets without reset gives undefined hit/miss results but must not corrupt stall counters.

Test Plan:
- Common setup: log2_num_sets=2, hit_latency=3, dram_latency=10.
- Cold miss: tid 0 reads 0x100 -> next clock ctr_miss=1; stay_stalled=1 for the next 13 tokens of tid 0, then 0 on the 14th.
- Hit: after the line fills, tid 0 reads 0x104 -> ctr_hit=1; stalled for 3 tokens.
- Dirty eviction:
  - writeback 0x100 -> no counter pulse.
  - Then tid 1 reads 0x180 (same set 0, different tag) -> ctr_miss=1, ctr_writeback=1.
- Combined token: writeback 0x200 with request 0x200 in the same token -> ctr_hit=1, ctr_writeback=0 (set 0 was clean).
- Interleaving: tid 2 stalled 13 while tid 3 tokens hit -> tid 3 sees 3-token stall; tid 2 counter is unaffected by tid 3 tokens.
- Reset mid-stall: rst=0 during tid 0 miss stall -> after release, stay_stalled=0; re-read of 0x100 misses again.
